// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch stage: owns the program counter, issues one read per
// cycle to instruction memory, buffers returned words with their PCs in a
// small prefetch FIFO and hands them to decode over a valid/ready handshake.
// A redirect from execute drops everything buffered or in flight and
// restarts fetch at the new PC.
module z16_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [15:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [15:0]   r_pc;
  logic          inflight_valid;
  logic [15:0]   inflight_pc;
  logic [15:0]   instr_mem [DEPTH];
  logic [15:0]   pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] credit_used;
  logic          fire;
  logic          push;
  logic          pop;

  // Every accepted request owns a FIFO slot from the moment it is issued, so
  // the slots in use are the buffered entries plus the one in flight.
  assign credit_used = {1'b0, count} + {{(AW+1){1'b0}}, inflight_valid};

  assign o_imem_req    = !i_rst && !i_redirect && (credit_used < DEPTH_W);
  assign o_imem_addr   = r_pc;
  assign fire          = o_imem_req && i_imem_ready;
  assign push          = inflight_valid;
  assign o_instr_valid = (count != '0);
  assign pop           = o_instr_valid && i_instr_ready;

  // The head is shown only while valid; an empty FIFO presents zeros.
  assign o_instr    = o_instr_valid ? instr_mem[rd_ptr] : 16'h0000;
  assign o_instr_pc = o_instr_valid ? pc_mem[rd_ptr]    : 16'h0000;

  // PC, in-flight tracking and FIFO bookkeeping; redirect overrides any
  // accept, push or pop happening in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc           <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= 16'h0000;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else if (i_redirect) begin
      r_pc           <= i_redirect_pc & 16'hFFFE;
      inflight_valid <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else begin
      if (fire) begin
        r_pc        <= r_pc + 16'd2;
        inflight_pc <= r_pc;
      end
      inflight_valid <= fire;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_redirect && push) begin
      instr_mem[wr_ptr] <= i_imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Self-checking bench for z16_fetch_unit: directed phases followed by random
// traffic, every cycle compared against a queue-based model of the fetch
// stage's externally visible behaviour.
module tb_z16_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] pc;
    int          cyc;
  } entry_t;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ready;
  logic [15:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        i_instr_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;

  int          nAsserts = 0;
  int          nFails   = 0;
  int          cyc      = 0;
  entry_t      q[$];
  logic [15:0] nextPc      = RESET_PC;
  logic        respPending = 1'b0;
  logic [15:0] respAddr    = 16'h0000;
  logic        prevRst     = 1'b0;

  z16_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Contents of instruction memory: distinct from the address so that a
  // swapped instruction/PC pair is caught.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model by what the rising edge should do.
  task automatic applyStimulus(input logic rst, input logic red, input logic [15:0] rpc,
                               input logic mready, input logic iready);
    logic expReq;
    logic expValid;
    expReq   = 1'b0;
    expValid = 1'b0;
    @(negedge i_clk);
    i_rst         = rst;
    i_redirect    = red;
    i_redirect_pc = rpc;
    i_imem_ready  = mready;
    i_instr_ready = iready;
    i_imem_rdata  = respPending ? memWord(respAddr) : 16'($urandom);
    #1;
    if (rst) begin
      checkOutput("req_in_reset", {15'b0, o_imem_req}, 16'h0000);
    end else begin
      expReq   = !red && (q.size() < DEPTH);
      expValid = (q.size() > 0) && (q[0].cyc <= cyc - 2);
      checkOutput("imem_req", {15'b0, o_imem_req}, {15'b0, expReq});
      if (expReq) checkOutput("imem_addr", o_imem_addr, nextPc);
      checkOutput("instr_valid", {15'b0, o_instr_valid}, {15'b0, expValid});
      if (expValid) begin
        checkOutput("instr_pc", o_instr_pc, q[0].pc);
        checkOutput("instr", o_instr, memWord(q[0].pc));
      end else if (prevRst) begin
        checkOutput("instr_after_rst", o_instr, 16'h0000);
        checkOutput("pc_after_rst", o_instr_pc, 16'h0000);
      end
    end
    respPending = o_imem_req && mready;
    respAddr    = o_imem_addr;
    if (rst) begin
      q.delete();
      nextPc = RESET_PC;
    end else if (red) begin
      q.delete();
      nextPc = {rpc[15:1], 1'b0};
    end else begin
      if (expValid && iready) void'(q.pop_front());
      if (expReq && mready) begin
        q.push_back('{pc: nextPc, cyc: cyc});
        nextPc = nextPc + 16'd2;
      end
    end
    prevRst = rst;
    cyc++;
    @(posedge i_clk);
  endtask

  initial begin
    logic rRst;
    logic rRed;
    logic rMready;
    logic rIready;
    i_rst         = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_imem_ready  = 1'b1;
    i_instr_ready = 1'b1;
    i_imem_rdata  = 16'h0000;
    $display("[TB] z16_fetch_unit bench starting");

    // Reset, then free-running fetch with both sides always ready
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Decode stalled long enough to fill the FIFO, then released
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Redirect with three entries buffered and one request in flight
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1235, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Redirect near the top of the address space to cross the wrap
    applyStimulus(1'b0, 1'b1, 16'hFFFD, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Random memory and decode back-pressure with occasional redirect/reset
    for (int i = 0; i < 400; i++) begin
      rRst    = ($urandom_range(0, 99) == 0);
      rRed    = ($urandom_range(0, 39) == 0);
      rMready = ($urandom_range(0, 3) != 0);
      rIready = ($urandom_range(0, 1) == 1);
      applyStimulus(rRst, rRed, 16'($urandom), rMready, rIready);
    end

    // One-cycle reset mid-stream with a response in flight
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
